// File: rtl/prio_rr_scheduler_if.sv
// Request/grant bundle between a set of requesters and prio_rr_scheduler.
// The scheduler takes the slave side; the requester side (or a testbench) takes master.
interface prio_rr_scheduler_if #(
    parameter int N = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic          timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/prio_rr_scheduler.sv
// Round-robin single-resource scheduler with an optional hold timeout.
//
//   state | meaning
//   IDLE  | no grant active; next edge grants the first requester at/after ptr
//   BUSY  | grant held steady until done or hold limit, then back to IDLE
//
// A released grant always passes through IDLE for one cycle, so grants are
// at least two cycles apart. MAX_HOLD = 0 disables the hold limit.
module prio_rr_scheduler #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    prio_rr_scheduler_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic          hold_last;

    function automatic int wrap_add(input int a, input int b);
        int s;
        s = a + b;
        return (s >= N) ? (s - N) : s;
    endfunction

    // Search requests cyclically starting at ptr; first hit wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!sel_found && bus.req[wrap_add(int'(ptr_q), k)]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(wrap_add(int'(ptr_q), k));
            end
        end
    end

    assign hold_last = (MAX_HOLD != 0) && (cnt_q == CNT_LAST);

    // Next-state logic: grant issue in IDLE, release (normal or forced) in BUSY.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sel_found) begin
                    state_d = BUSY;
                    idx_d   = sel_idx;
                    ptr_d   = (sel_idx == IDX_LAST) ? '0 : sel_idx + 1'b1;
                end
            end
            BUSY: begin
                if (bus.done || hold_last) begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    cnt_d     = '0;
                    timeout_d = !bus.done;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset wins over done and req.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt_valid = (state_q == BUSY);
    assign bus.gnt       = (state_q == BUSY) ? (N'(1) << idx_q) : '0;
    assign bus.gnt_idx   = idx_q;
    assign bus.timeout   = timeout_q;

`ifndef SYNTHESIS
    logic grant_issue;
    int   run_len;
    int   wait_cnt [N];

    assign grant_issue = (state_q == IDLE) && sel_found;

    // Length of the current grant so far, for the hold-limit check.
    always_ff @(posedge clk) begin
        if (rst || !bus.gnt_valid) run_len <= 0;
        else                       run_len <= run_len + 1;
    end

    // Grants issued to others while requester i keeps its request high.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst || !bus.req[i] || (grant_issue && sel_idx == IW'(i))) wait_cnt[i] <= 0;
            else if (grant_issue)                                        wait_cnt[i] <= wait_cnt[i] + 1;
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.gnt));
    a_valid:  assert property (@(posedge clk) disable iff (rst) bus.gnt_valid == (bus.gnt != '0));
    a_idx:    assert property (@(posedge clk) disable iff (rst) bus.gnt_valid |-> bus.gnt[bus.gnt_idx]);
    a_req:    assert property (@(posedge clk) disable iff (rst)
                  (bus.gnt_valid && !$past(bus.gnt_valid)) |-> (($past(bus.req) & bus.gnt) != '0));
    a_hold:   assert property (@(posedge clk) disable iff (rst)
                  ((MAX_HOLD != 0) && bus.gnt_valid) |-> (run_len < MAX_HOLD));

    for (genvar g = 0; g < N; g++) begin : g_fair
        a_fair: assert property (@(posedge clk) disable iff (rst) wait_cnt[g] < N);
    end
`endif
endmodule

// File: tb/tb_prio_rr_scheduler.sv
// Directed bench for prio_rr_scheduler (N=8, MAX_HOLD=16). The stimulus
// process queues the expected grant record (index, hold length, timeout flag)
// and a monitor pops and compares each time a grant ends.
module tb_prio_rr_scheduler;
    localparam int N        = 8;
    localparam int MAX_HOLD = 16;

    typedef struct {
        int idx;
        int len;
        int to;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    prio_rr_scheduler_if #(.N(N)) bus ();

    prio_rr_scheduler #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, want);
        end
    endtask

    task automatic expect_grant(input int idx, input int len, input int to);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.to  = to;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: track each grant from rise to fall and score it.
    bit in_grant = 1'b0;
    int cur_idx, cur_gnt, cur_len;
    always @(negedge clk) begin
        if (bus.gnt_valid) begin
            if (!in_grant) begin
                in_grant = 1'b1;
                cur_idx  = int'(bus.gnt_idx);
                cur_gnt  = int'(bus.gnt);
                cur_len  = 1;
            end else begin
                cur_len++;
                chk("grant steady idx", int'(bus.gnt_idx), cur_idx);
                chk("grant steady gnt", int'(bus.gnt), cur_gnt);
            end
        end else if (in_grant) begin
            exp_t e;
            in_grant = 1'b0;
            if (exp_q.size() == 0) begin
                chk("unexpected grant idx", cur_idx, -1);
            end else begin
                e = exp_q.pop_front();
                chk("grant idx", cur_idx, e.idx);
                chk("grant vector", cur_gnt, 1 << e.idx);
                chk("grant length", cur_len, e.len);
                chk("release timeout", int'(bus.timeout), e.to);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst      = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset gnt", int'(bus.gnt), 0);
        chk("reset gnt_idx", int'(bus.gnt_idx), 0);
        chk("reset gnt_valid", int'(bus.gnt_valid), 0);
        chk("reset timeout", int'(bus.timeout), 0);

        // idle with no requests; done must be ignored
        rst      = 1'b0;
        bus.done = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle gnt_valid", int'(bus.gnt_valid), 0);
        chk("idle gnt", int'(bus.gnt), 0);
        chk("idle timeout", int'(bus.timeout), 0);
        bus.done = 1'b0;

        // rotation: req=0000_0101, done in 3rd busy cycle -> 0, 2, 0
        expect_grant(0, 3, 0);
        expect_grant(2, 3, 0);
        expect_grant(0, 3, 0);
        bus.req = 8'h05;
        @(negedge clk);
        chk("rot latency", int'(bus.gnt_valid), 1);
        for (int g = 0; g < 3; g++) begin
            if (g > 0) begin
                @(negedge clk);
                chk("rot regrant", int'(bus.gnt_valid), 1);
            end
            repeat (2) @(negedge clk);
            bus.done = 1'b1;
            if (g == 2) bus.req = '0;
            @(negedge clk);
            bus.done = 1'b0;
            chk("rot gap", int'(bus.gnt_valid), 0);
        end

        // wrap-around from ptr=0, holder drops req mid-grant
        do_reset();
        expect_grant(7, 2, 0);
        expect_grant(0, 1, 0);
        bus.req = 8'h80;
        @(negedge clk);
        chk("wrap latency", int'(bus.gnt_valid), 1);
        chk("wrap gnt", int'(bus.gnt), 8'h80);
        chk("wrap gnt_idx", int'(bus.gnt_idx), 7);
        bus.req = 8'h01;
        @(negedge clk);
        bus.done = 1'b1;
        bus.req  = 8'hFF;
        @(negedge clk);
        bus.done = 1'b0;
        chk("wrap release", int'(bus.gnt_valid), 0);
        @(negedge clk);
        chk("wrap ptr reuse idx", int'(bus.gnt_idx), 0);
        bus.done = 1'b1;
        bus.req  = '0;
        @(negedge clk);
        bus.done = 1'b0;

        // forced release after 16 cycles (ptr=1, req at 4)
        expect_grant(4, 16, 1);
        bus.req = 8'h10;
        @(negedge clk);
        chk("to latency", int'(bus.gnt_valid), 1);
        bus.req = '0;
        n = 0;
        while (bus.gnt_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("to release valid", int'(bus.gnt_valid), 0);
        chk("to pulse", int'(bus.timeout), 1);
        @(negedge clk);
        chk("to one cycle", int'(bus.timeout), 0);

        // done together with last hold cycle is a normal release
        expect_grant(3, 16, 0);
        bus.req = 8'h08;
        @(negedge clk);
        chk("simul latency", int'(bus.gnt_valid), 1);
        bus.req = '0;
        repeat (15) @(negedge clk);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        chk("simul release", int'(bus.gnt_valid), 0);
        chk("simul timeout", int'(bus.timeout), 0);

        // full load: grant every 2 cycles, 0..7 then 0
        do_reset();
        for (int g = 0; g < 9; g++) expect_grant(g % 8, 1, 0);
        bus.req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            @(negedge clk);
            chk("load grant", int'(bus.gnt_valid), 1);
            bus.done = 1'b1;
            if (g == 8) bus.req = '0;
            @(negedge clk);
            chk("load gap", int'(bus.gnt_valid), 0);
            bus.done = 1'b0;
        end

        // reset while granting index 5 (ptr=1); reset beats done
        expect_grant(5, 2, 0);
        expect_grant(0, 1, 0);
        bus.req = 8'h20;
        @(negedge clk);
        chk("rst grant idx", int'(bus.gnt_idx), 5);
        @(negedge clk);
        rst      = 1'b1;
        bus.req  = 8'hFF;
        bus.done = 1'b1;
        @(negedge clk);
        chk("rst gnt", int'(bus.gnt), 0);
        chk("rst gnt_valid", int'(bus.gnt_valid), 0);
        chk("rst timeout", int'(bus.timeout), 0);
        rst      = 1'b0;
        bus.done = 1'b0;
        @(negedge clk);
        chk("post-rst valid", int'(bus.gnt_valid), 1);
        chk("post-rst idx", int'(bus.gnt_idx), 0);
        bus.done = 1'b1;
        bus.req  = '0;
        @(negedge clk);
        bus.done = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
